// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - memory-side line-fill responder for the LRU cache backend
//
// Accepts line-address requests into a small FIFO, waits a fixed read latency and
// returns one full line per request, in request order. Line content is a fixed
// function of the address: word i of line a = {a[31:0], i[31:0]}; addresses at or
// beyond MEM_LINES return an all-ones line and bump err_cnt.
//
// Ports:
//   clk                      in   clock, rising edge
//   rstn                     in   asynchronous active-low reset
//   req_addr_stream_tdata    in   [TAGS_WIDTH-1:0] requested line address
//   req_addr_stream_tvalid   in   request valid
//   req_addr_stream_tready   out  request FIFO has room (registered)
//   bak_data_stream_tdata    out  [CACHE_SIZE-1:0] returned line
//   bak_data_stream_tvalid   out  line valid, held until accepted
//   bak_data_stream_tready   in   consumer accepts line
//   busy                     out  FIFO non-empty or FSM not idle
//   req_cnt                  out  [31:0] accepted requests, wrapping
//   err_cnt                  out  [15:0] out-of-range requests, saturating
module line_fill_responder #(
  parameter int TAGS_WIDTH     = 48,
  parameter int CACHE_SIZE     = 512,
  parameter int MEM_LINES      = 256,
  parameter int READ_LATENCY   = 4,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [TAGS_WIDTH-1:0] req_addr_stream_tdata,
  input  logic                  req_addr_stream_tvalid,
  output logic                  req_addr_stream_tready,
  output logic [CACHE_SIZE-1:0] bak_data_stream_tdata,
  output logic                  bak_data_stream_tvalid,
  input  logic                  bak_data_stream_tready,
  output logic                  busy,
  output logic [31:0]           req_cnt,
  output logic [15:0]           err_cnt
);

  localparam int PTR_W  = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LAT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam int WORDS  = CACHE_SIZE / 64;

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REQ_FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Request FIFO: pointers carry one extra bit so full and empty are distinguishable.
  logic [TAGS_WIDTH-1:0] r_fifo_mem [REQ_FIFO_DEPTH];
  logic [CNT_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_rd_ptr;
  logic                  r_req_tready;

  logic [1:0]            r_state;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [31:0]           r_addr_lo;
  logic                  r_oor;
  logic [CACHE_SIZE-1:0] r_bak_tdata;
  logic                  r_bak_tvalid;
  logic [31:0]           r_req_cnt;
  logic [15:0]           r_err_cnt;

  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_count_next;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [TAGS_WIDTH-1:0] w_head;
  logic                  w_head_oor;
  logic [CACHE_SIZE-1:0] w_pattern;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_count == '0);
  assign w_push     = req_addr_stream_tvalid && r_req_tready;
  assign w_head     = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_head_oor = (w_head >= TAGS_WIDTH'(MEM_LINES));

  // The FIFO head leaves either from IDLE or on a response handshake, which lets
  // back-to-back requests skip the IDLE cycle.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_RESP) && bak_data_stream_tready));

  assign w_count_next = w_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= req_addr_stream_tdata;
    end
  end

  // tready is registered from the post-edge occupancy, so it stays low out of reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_req_tready <= 1'b0;
      r_req_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + CNT_W'(1);
        r_req_cnt <= r_req_cnt + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      end
      r_req_tready <= (w_count_next != CNT_FULL);
    end
  end

  always_comb begin
    w_pattern = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_pattern[i*64 +: 64] = {r_addr_lo, 32'(i)};
    end
    if (r_oor) begin
      w_pattern = '1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_addr_lo    <= '0;
      r_oor        <= 1'b0;
      r_bak_tdata  <= '0;
      r_bak_tvalid <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      if (w_pop) begin
        r_addr_lo <= w_head[31:0];
        r_oor     <= w_head_oor;
        r_lat_cnt <= LAT_LOAD;
        if (w_head_oor && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_bak_tdata  <= w_pattern;
            r_bak_tvalid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (bak_data_stream_tready) begin
            r_bak_tvalid <= 1'b0;
            r_state      <= w_pop ? S_WAIT : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_addr_stream_tready = r_req_tready;
  assign bak_data_stream_tdata  = r_bak_tdata;
  assign bak_data_stream_tvalid = r_bak_tvalid;
  assign busy                   = !w_empty || (r_state != S_IDLE);
  assign req_cnt                = r_req_cnt;
  assign err_cnt                = r_err_cnt;

endmodule

// File: tb/tb_line_fill_responder.sv
// tb/tb_line_fill_responder.sv - scoreboard bench for line_fill_responder
module tb_line_fill_responder;

  localparam int TW = 48;
  localparam int CS = 512;

  logic          clk;
  logic          rstn;
  logic [TW-1:0] req_tdata;
  logic          req_tvalid;
  logic          req_tready;
  logic [CS-1:0] bak_tdata;
  logic          bak_tvalid;
  logic          bak_tready;
  logic          busy;
  logic [31:0]   req_cnt;
  logic [15:0]   err_cnt;

  line_fill_responder #(
    .TAGS_WIDTH(TW), .CACHE_SIZE(CS), .MEM_LINES(256),
    .READ_LATENCY(4), .REQ_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_addr_stream_tdata(req_tdata),
    .req_addr_stream_tvalid(req_tvalid),
    .req_addr_stream_tready(req_tready),
    .bak_data_stream_tdata(bak_tdata),
    .bak_data_stream_tvalid(bak_tvalid),
    .bak_data_stream_tready(bak_tready),
    .busy(busy),
    .req_cnt(req_cnt),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            n_push = 0;
  int            n_resp = 0;
  int            accept_cyc = 0;
  int            rise_cyc = 0;
  int            last_hs = 0;
  logic          have_hs = 1'b0;
  logic          prev_tv = 1'b0;
  logic          chk_b2b = 1'b0;
  logic [CS-1:0] last_data = '0;
  logic [CS-1:0] sb [$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [CS-1:0] got, input logic [CS-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %0s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [CS-1:0] line_of(input logic [TW-1:0] a);
    logic [CS-1:0] l;
    l = '0;
    for (int i = 0; i < CS / 64; i++) l[i*64 +: 64] = {a[31:0], 32'(i)};
    if (a >= 48'd256) l = '1;
    return l;
  endfunction

  // Response monitor: samples on the falling edge, so a tvalid&tready seen here
  // completes on the following rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_tv = 1'b0;
      have_hs = 1'b0;
    end else begin
      if (bak_tvalid && !prev_tv) begin
        rise_cyc = cyc;
        if (chk_b2b && have_hs) check("b2b_latency", CS'(rise_cyc - last_hs), CS'(3));
      end
      if (bak_tvalid && bak_tready) begin
        if (sb.size() == 0) begin
          check("spurious_resp", CS'(n_resp + 1), CS'(n_push));
        end else begin
          check("resp_data", bak_tdata, sb.pop_front());
        end
        last_data = bak_tdata;
        n_resp++;
        last_hs = cyc + 1;
        have_hs = 1'b1;
      end
      prev_tv = bak_tvalid;
    end
  end

  task automatic do_reset(input logic check_state);
    req_tvalid = 1'b0;
    rstn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    sb.delete();
    n_push = 0;
    n_resp = 0;
    if (check_state) begin
      check("rst_tvalid", CS'(bak_tvalid), CS'(0));
      check("rst_tdata", bak_tdata, CS'(0));
      check("rst_tready", CS'(req_tready), CS'(0));
      check("rst_busy", CS'(busy), CS'(0));
      check("rst_req_cnt", CS'(req_cnt), CS'(0));
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("tready_after_rst", CS'(req_tready), CS'(1));
  endtask

  task automatic send_req(input logic [TW-1:0] a, output int stalls);
    req_tdata = a;
    req_tvalid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!req_tready && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (!req_tready) begin
      check("req_accept_timeout", CS'(req_tready), CS'(1));
    end else begin
      @(posedge clk);
      #1;
      sb.push_back(line_of(a));
      accept_cyc = cyc;
      n_push++;
    end
    req_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", CS'(sb.size()), CS'(0));
    check("drain_busy", CS'(busy), CS'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int st;
    int stalled;
    int n;
    int resp_before;
    req_tdata = '0;
    req_tvalid = 1'b0;
    bak_tready = 1'b0;
    rstn = 1'b0;

    // Reset state
    do_reset(1'b1);

    // Single read, latency and word pattern
    bak_tready = 1'b1;
    send_req(48'd3, st);
    wait_drain(100);
    check("single_latency", CS'(rise_cyc - accept_cyc), CS'(4));
    check("single_word0", CS'(last_data[63:0]), CS'(64'h00000003_00000000));
    check("single_word7", CS'(last_data[511:448]), CS'(64'h00000003_00000007));
    check("single_req_cnt", CS'(req_cnt), CS'(1));

    // Burst 0..5: FIFO fills, responses in order, back-to-back latency
    do_reset(1'b0);
    bak_tready = 1'b1;
    chk_b2b = 1'b1;
    stalled = 0;
    for (int i = 0; i < 6; i++) begin
      send_req(TW'(i), st);
      stalled += st;
    end
    wait_drain(200);
    chk_b2b = 1'b0;
    check("burst_backpressured", CS'(stalled > 0), CS'(1));
    check("burst_resp_count", CS'(n_resp), CS'(6));
    check("burst_req_cnt", CS'(req_cnt), CS'(6));

    // Backpressure: response held 20 cycles, queued request not lost
    do_reset(1'b0);
    bak_tready = 1'b0;
    send_req(48'd9, st);
    send_req(48'd10, st);
    n = 0;
    while (!bak_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_tvalid_rise", CS'(bak_tvalid), CS'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_valid", CS'(bak_tvalid), CS'(1));
      check("bp_hold_data", bak_tdata, line_of(48'd9));
    end
    bak_tready = 1'b1;
    wait_drain(100);
    check("bp_resp_count", CS'(n_resp), CS'(2));

    // Out of range followed by a valid address
    do_reset(1'b0);
    bak_tready = 1'b1;
    send_req(48'd256, st);
    send_req(48'd7, st);
    wait_drain(100);
    check("oor_err_cnt", CS'(err_cnt), CS'(1));
    check("oor_next_line", last_data, line_of(48'd7));
    check("oor_req_cnt", CS'(req_cnt), CS'(2));

    // Reset while the first of three requests is waiting on latency
    do_reset(1'b0);
    bak_tready = 1'b1;
    send_req(48'd10, st);
    send_req(48'd11, st);
    send_req(48'd12, st);
    check("mid_busy_before", CS'(busy), CS'(1));
    check("mid_no_resp_yet", CS'(bak_tvalid), CS'(0));
    resp_before = n_resp;
    rstn = 1'b0;
    #1;
    sb.delete();
    check("mid_tvalid", CS'(bak_tvalid), CS'(0));
    check("mid_busy", CS'(busy), CS'(0));
    check("mid_req_cnt", CS'(req_cnt), CS'(0));
    check("mid_err_cnt", CS'(err_cnt), CS'(0));
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_no_responses", CS'(n_resp), CS'(resp_before));
    check("mid_idle_busy", CS'(busy), CS'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
